// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack
// handshake and holds each instruction for decode until it retires.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        iCLK,
    input  logic        iRSTn,
    output logic        oIMemReq,
    output logic [31:0] oIMemAddr,
    input  logic        iIMemAck,
    input  logic [31:0] iIMemData,
    output logic [31:0] oInst,
    output logic        oInstValid,
    output logic [31:0] oPC,
    output logic [31:0] oPCPlus4,
    input  logic        iRetire,
    input  logic [1:0]  iOrigPC,
    input  logic        iBranch,
    input  logic        iZero,
    input  logic [31:0] iImm,
    output logic        oHalt,
    output logic        oFault
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        HALT
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] inst_q;
    logic        fault;

    logic [31:0] pc_seq;
    logic [31:0] pc_br;
    logic [31:0] target;
    logic        halt_sel;
    logic        misaligned;

    // Next-PC selection from control and the ALU zero flag
    always_comb begin
        pc_seq   = pc + 32'd4;
        pc_br    = pc + iImm;
        target   = pc_seq;
        halt_sel = 1'b0;
        unique case (iOrigPC)
            2'b00: target = pc_seq;
            2'b01: target = (iBranch && iZero) ? pc_br : pc_seq;
            2'b10: target = pc_br;
            2'b11: begin
                target   = pc;
                halt_sel = 1'b1;
            end
        endcase
        misaligned = (target[1:0] != 2'b00);
    end

    // Fetch state machine, PC and instruction register
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            inst_q <= NOP_INST;
            fault  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (iIMemAck) begin
                        inst_q <= iIMemData;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (iRetire) begin
                        if (halt_sel) begin
                            state <= HALT;
                        end else if (misaligned) begin
                            fault <= 1'b1;
                            state <= HALT;
                        end else begin
                            pc    <= target;
                            state <= FETCH;
                        end
                    end
                end
                HALT: state <= HALT;
            endcase
        end
    end

    assign oIMemReq   = (state == FETCH);
    assign oInstValid = (state == HOLD);
    assign oHalt      = (state == HALT);
    assign oFault     = fault;
    assign oIMemAddr  = pc;
    assign oPC        = pc;
    assign oPCPlus4   = pc + 32'd4;
    assign oInst      = (state == HOLD) ? inst_q : NOP_INST;

endmodule
